mod_updown_counter: RTL and testbench

//  Parametrised modulo-N up/down counter with synchronous load, clear and step enable.

---
 rtl/mod_updown_counter_pkg.sv | 19 +
 rtl/mod_updown_counter_if.sv | 23 ++
 rtl/mod_updown_counter_tick_gen.sv | 30 +++
 rtl/mod_updown_counter.sv | 102 ++++++++++
 tb/tb_mod_updown_counter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mod_updown_counter_pkg.sv
// Shared types and elaboration-time helpers for the modulo-N up/down counter.
package mod_updown_counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Out-of-range load values pin to the top of the count range.
  function automatic int clamp_load(int val, int modulus);
    return (val < modulus) ? val : modulus - 1;
  endfunction

  function automatic bit cnt_params_ok(int width, int modulus, int prescale);
    return (width >= 1) && (modulus >= 2) &&
           (longint'(modulus) <= (longint'(1) << width)) && (prescale >= 1);
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control inputs and count/tc/tick outputs of the up/down counter.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             tick;

  modport master (
    output en, up, clr, load, load_val,
    input  count, tc, tick
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, tc, tick
  );
endinterface

// File: rtl/mod_updown_counter_tick_gen.sv
// Free-running prescaler: registered 1-cycle tick every PRESCALE clk, first one PRESCALE
// cycles after reset/sclr. Latency 1 cycle; no backpressure.
module mod_updown_counter_tick_gen #(
  parameter int PRESCALE = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic sclr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (sclr) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pcnt == LAST);
      pcnt <= (pcnt == LAST) ? '0 : pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter, clr > load > step > hold, WRAP or SAT at the limits.
// Latency 1 cycle from qualifying tick to count/tc; no backpressure, outputs valid every cycle.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int        WIDTH    = 4,
  parameter int        MODULUS  = 16,
  parameter int        PRESCALE = 32,
  parameter cnt_mode_e MODE     = CNT_WRAP
) (
  input logic                 clk,
  input logic                 rst,
  mod_updown_counter_if.slave bus
);

  localparam bit PARAMS_OK = cnt_params_ok(WIDTH, MODULUS, PRESCALE);

  if (!PARAMS_OK) begin : g_bad_params
    $error("mod_updown_counter: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  localparam int            CW   = WIDTH + 1;
  localparam logic [CW-1:0] MAXV = CW'(MODULUS - 1);

  logic             tick;
  logic             step;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             hit_q, hit_d;
  logic [CW-1:0]    cnt_ext;

  mod_updown_counter_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .sclr (bus.clr),
    .tick (tick)
  );

  assign step    = bus.en & tick;
  assign cnt_ext = {1'b0, count_q};

  // hit_q remembers that the saturating limit was already reported, so tc fires once.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    hit_d   = hit_q;
    if (bus.clr) begin
      count_d = '0;
      hit_d   = 1'b0;
    end else if (bus.load) begin
      count_d = WIDTH'(clamp_load(32'(bus.load_val), MODULUS));
      hit_d   = 1'b0;
    end else if (step) begin
      if (bus.up) begin
        if (cnt_ext == MAXV) begin
          if (MODE == CNT_WRAP) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            tc_d  = ~hit_q;
            hit_d = 1'b1;
          end
        end else begin
          count_d = WIDTH'(cnt_ext + CW'(1));
          hit_d   = 1'b0;
        end
      end else begin
        if (cnt_ext == '0) begin
          if (MODE == CNT_WRAP) begin
            count_d = WIDTH'(MAXV);
            tc_d    = 1'b1;
          end else begin
            tc_d  = ~hit_q;
            hit_d = 1'b1;
          end
        end else begin
          count_d = WIDTH'(cnt_ext - CW'(1));
          hit_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.tick  = tick;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised scoreboard bench: three counter configurations share one stimulus stream.
module tb_mod_updown_counter;
  import mod_updown_counter_pkg::*;

  localparam int M = 10;

  typedef struct packed {
    logic [3:0] cnt;
    logic       tc;
    logic       tick;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(4)) ifa ();
  mod_updown_counter_if #(.WIDTH(4)) ifb ();
  mod_updown_counter_if #(.WIDTH(4)) ifc ();

  mod_updown_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1),  .MODE(CNT_WRAP)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  mod_updown_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1),  .MODE(CNT_SAT))  dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));
  mod_updown_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(32), .MODE(CNT_WRAP)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc.slave));

  int checks = 0;
  int errors = 0;

  obs_t qa[$];
  obs_t qb[$];
  obs_t qc[$];

  // Reference state: value, last tc, current tick, "limit already reported", edges since clear.
  int m_cnt[3];
  bit m_tc[3];
  bit m_tick[3];
  bit m_hit[3];
  int m_since[3];

  function automatic int pre_of(int i);
    return (i == 2) ? 32 : 1;
  endfunction

  function automatic bit sat_of(int i);
    return (i == 1);
  endfunction

  function automatic void cmp(string nm, obs_t got, obs_t ex);
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s got count=%0d tc=%0d tick=%0d expected count=%0d tc=%0d tick=%0d",
               nm, got.cnt, got.tc, got.tick, ex.cnt, ex.tc, ex.tick);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_tick[i] = 0; m_hit[i] = 0; m_since[i] = 0;
    end
  endfunction

  function automatic void model_edge(int i, bit e, bit u, bit c, bit l, int lv);
    int lim;
    if (c) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_hit[i] = 0; m_since[i] = 0; m_tick[i] = 0;
      return;
    end
    if (l) begin
      m_cnt[i] = (lv < M) ? lv : M - 1;
      m_tc[i]  = 0;
      m_hit[i] = 0;
    end else if (e && m_tick[i]) begin
      lim = u ? M - 1 : 0;
      if (m_cnt[i] == lim) begin
        if (sat_of(i)) begin
          m_tc[i]  = !m_hit[i];
          m_hit[i] = 1;
        end else begin
          m_cnt[i] = u ? 0 : M - 1;
          m_tc[i]  = 1;
        end
      end else begin
        m_cnt[i] = m_cnt[i] + (u ? 1 : -1);
        m_tc[i]  = 0;
        m_hit[i] = 0;
      end
    end else begin
      m_tc[i] = 0;
    end
    m_since[i]++;
    m_tick[i] = (m_since[i] % pre_of(i)) == 0;
  endfunction

  function automatic obs_t expect_of(int i);
    obs_t o;
    o.cnt  = 4'(m_cnt[i]);
    o.tc   = m_tc[i];
    o.tick = m_tick[i];
    return o;
  endfunction

  task automatic drive(bit e, bit u, bit c, bit l, int lv);
    ifa.en = e; ifa.up = u; ifa.clr = c; ifa.load = l; ifa.load_val = 4'(lv);
    ifb.en = e; ifb.up = u; ifb.clr = c; ifb.load = l; ifb.load_val = 4'(lv);
    ifc.en = e; ifc.up = u; ifc.clr = c; ifc.load = l; ifc.load_val = 4'(lv);
    for (int i = 0; i < 3; i++) model_edge(i, e, u, c, l, lv);
    @(posedge clk);
    qa.push_back(expect_of(0));
    qb.push_back(expect_of(1));
    qc.push_back(expect_of(2));
    #1;
  endtask

  task automatic check_all_zero(string nm);
    obs_t z;
    z = '0;
    cmp({nm, "_a"}, {ifa.count, ifa.tc, ifa.tick}, z);
    cmp({nm, "_b"}, {ifb.count, ifb.tc, ifb.tick}, z);
    cmp({nm, "_c"}, {ifc.count, ifc.tc, ifc.tick}, z);
  endtask

  // Monitor: outputs are presented every cycle; compare whatever the stimulus queued.
  always @(negedge clk) begin
    if (qa.size() > 0) cmp("wrap_p1", {ifa.count, ifa.tc, ifa.tick}, qa.pop_front());
    if (qb.size() > 0) cmp("sat_p1",  {ifb.count, ifb.tc, ifb.tick}, qb.pop_front());
    if (qc.size() > 0) cmp("wrap_p32", {ifc.count, ifc.tc, ifc.tick}, qc.pop_front());
  end

  initial begin
    bit e, u, c, l, ub;
    int lv;
    rst = 1'b0;
    ifa.en = 0; ifa.up = 0; ifa.clr = 0; ifa.load = 0; ifa.load_val = '0;
    ifb.en = 0; ifb.up = 0; ifb.clr = 0; ifb.load = 0; ifb.load_val = '0;
    ifc.en = 0; ifc.up = 0; ifc.clr = 0; ifc.load = 0; ifc.load_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); #1;
    rst = 1'b1;

    // Count up through the limit: wrap rolls 9->0, saturating config holds at 9.
    repeat (14) drive(1, 1, 0, 0, 0);
    // Down step from 0.
    drive(0, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // clr beats load and step; out-of-range load clamps.
    drive(1, 1, 1, 1, 5);
    drive(0, 0, 0, 1, 12);

    // Asynchronous reset with count at 9, observed without any clock edge.
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;

    // Prescaler phase across a clr.
    repeat (70) drive(1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    repeat (70) drive(1, 1, 0, 0, 0);

    // Random traffic with a direction bias that flips every 50 cycles.
    for (int k = 0; k < 3000; k++) begin
      ub = ((k / 50) % 2) == 0;
      u  = ($urandom_range(0, 4) != 0) ? ub : !ub;
      e  = $urandom_range(0, 7) != 0;
      c  = $urandom_range(0, 199) == 0;
      l  = $urandom_range(0, 23) == 0;
      lv = int'($urandom_range(0, 15));
      drive(e, u, c, l, lv);
    end

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
